// File: rtl/posix_time_split_seq_pkg.sv
// Shared constants, field types and FSM encoding for the POSIX time splitter.
// Optional weekday path is enabled with macro POSIX_SPLIT_WEEKDAY_EN.
package posix_time_pkg;

    localparam int unsigned SEC_IN_MIN  = 60;
    localparam int unsigned MIN_IN_HOUR = 60;
    localparam int unsigned HOUR_IN_DAY = 24;
    localparam int unsigned SEC_IN_HOUR = SEC_IN_MIN * MIN_IN_HOUR;
    localparam int unsigned SEC_IN_DAY  = SEC_IN_HOUR * HOUR_IN_DAY;

    localparam int unsigned POSIX_W    = 32;
    localparam int unsigned DIV_W      = 33;
    localparam int unsigned DIV_CYCLES = DIV_W;
    localparam int unsigned DIVISOR_W  = 17;
    localparam int unsigned DIV_CNT_W  = 6;

    localparam int unsigned HOUR_W = 5;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned SEC_W  = 6;

`ifdef POSIX_SPLIT_WEEKDAY_EN
    localparam int unsigned DAYS_IN_WEEK = 7;
    localparam int unsigned EPOCH_WDAY   = 4;  // 1970-01-01 was a Thursday
    localparam int unsigned QDAY_W       = 16;
    localparam int unsigned WDAY_W       = 3;
    typedef logic [WDAY_W-1:0] wday_t;
`endif

    typedef logic [HOUR_W-1:0] hour_t;
    typedef logic [MIN_W-1:0]  min_t;
    typedef logic [SEC_W-1:0]  sec_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADJ,
        ST_DIV_DAY,
        ST_DIV_HOUR,
        ST_DIV_MIN,
`ifdef POSIX_SPLIT_WEEKDAY_EN
        ST_DIV_WDAY,
`endif
        ST_OUT
    } state_t;

endpackage

// File: rtl/posix_time_split_seq_if.sv
// Request/result bundle between the time source, the splitter and the display.
// Signals: posix_time_i/valid_i/ready_o (request), hour_o/min_o/sec_o/valid_o/ready_i
// (result), wday_o when POSIX_SPLIT_WEEKDAY_EN is defined.
interface posix_time_split_seq_if;
    import posix_time_pkg::*;

    logic [POSIX_W-1:0] posix_time_i;
    logic               valid_i;
    logic               ready_o;
    hour_t              hour_o;
    min_t               min_o;
    sec_t               sec_o;
    logic               valid_o;
    logic               ready_i;
`ifdef POSIX_SPLIT_WEEKDAY_EN
    wday_t              wday_o;
`endif

    modport slave (
        input  posix_time_i, valid_i, ready_i,
        output ready_o, hour_o, min_o, sec_o, valid_o
`ifdef POSIX_SPLIT_WEEKDAY_EN
        , output wday_o
`endif
    );

    modport master (
        output posix_time_i, valid_i, ready_i,
        input  ready_o, hour_o, min_o, sec_o, valid_o
`ifdef POSIX_SPLIT_WEEKDAY_EN
        , input wday_o
`endif
    );

endinterface

// File: rtl/posix_time_split_seq_divider.sv
// seq_divider: restoring radix-2 divider, one quotient bit per cycle.
// Ports: i_clk, i_rst (sync, active-high), i_start (load cycle), i_dividend (33b),
// i_divisor (17b), o_quotient, o_remainder, o_done_c (high during last iteration).
// A pass is the load cycle plus DIV_CYCLES iterations; results hold until next load.
module seq_divider
    import posix_time_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [DIV_W-1:0]     i_dividend,
    input  logic [DIVISOR_W-1:0] i_divisor,
    output logic [DIV_W-1:0]     o_quotient,
    output logic [DIVISOR_W-1:0] o_remainder,
    output logic                 o_done_c
);

    logic [DIV_W-1:0]     r_quo;
    logic [DIVISOR_W-1:0] r_rem;
    logic [DIVISOR_W-1:0] r_dvs;
    logic [DIV_CNT_W-1:0] r_cnt;

    logic [DIVISOR_W:0]   w_shift;
    logic [DIVISOR_W:0]   w_trial;
    logic                 w_fits;

    // Shift next dividend bit into the partial remainder and try a subtract.
    always_comb begin
        w_shift = {r_rem, r_quo[DIV_W-1]};
        w_trial = w_shift - {1'b0, r_dvs};
        w_fits  = (w_shift >= {1'b0, r_dvs});
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_quo <= '0;
            r_rem <= '0;
            r_dvs <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_quo <= i_dividend;
            r_rem <= '0;
            r_dvs <= i_divisor;
            r_cnt <= DIV_CNT_W'(DIV_CYCLES);
        end else if (r_cnt != '0) begin
            // Remainder stays below the divisor, so the low bits suffice.
            r_rem <= w_fits ? w_trial[DIVISOR_W-1:0] : w_shift[DIVISOR_W-1:0];
            r_quo <= {r_quo[DIV_W-2:0], w_fits};
            r_cnt <= r_cnt - DIV_CNT_W'(1);
        end
    end

    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;
    assign o_done_c    = (r_cnt == DIV_CNT_W'(1));

endmodule

// File: rtl/posix_time_split_seq.sv
// posix_time_split_seq: POSIX seconds -> local hour/min/sec through one shared
// iterative divider (passes: day, hour, minute[, weekday]).
// Ports: clk_i, rst_i (sync, active-high), bus (posix_time_split_seq_if.slave).
// Parameter GMT: signed whole-hour zone offset (-12..14).
// Macro POSIX_SPLIT_WEEKDAY_EN adds wday_o and a weekday divider pass.
module posix_time_split_seq
    import posix_time_pkg::*;
#(
    parameter int GMT = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    posix_time_split_seq_if.slave bus
);

    localparam logic signed [33:0] OFFSET = 34'(GMT * int'(SEC_IN_HOUR));

    state_t               r_state, w_nxt_state;
    logic                 r_start, w_nxt_start;
    logic [POSIX_W-1:0]   r_posix, w_nxt_posix;
    logic [DIV_W-1:0]     r_t, w_nxt_t;
    hour_t                r_hour, w_nxt_hour;
    logic                 r_ready, w_nxt_ready;
    logic                 r_valid, w_nxt_valid;
    hour_t                r_hour_o, w_nxt_hour_o;
    min_t                 r_min_o, w_nxt_min_o;
    sec_t                 r_sec_o, w_nxt_sec_o;
`ifdef POSIX_SPLIT_WEEKDAY_EN
    logic                 r_borrow, w_nxt_borrow;
    logic [QDAY_W-1:0]    r_qday, w_nxt_qday;
    min_t                 r_min, w_nxt_min;
    sec_t                 r_sec, w_nxt_sec;
    wday_t                r_wday_o, w_nxt_wday_o;
`endif

    logic signed [33:0]   w_adj;
    logic [DIV_W-1:0]     w_dividend;
    logic [DIVISOR_W-1:0] w_divisor;
    logic [DIV_W-1:0]     w_quo;
    logic [DIVISOR_W-1:0] w_rem;
    logic                 w_done_c;
    logic                 w_div_done;

    seq_divider u_div (
        .i_clk       (clk_i),
        .i_rst       (rst_i),
        .i_start     (r_start),
        .i_dividend  (w_dividend),
        .i_divisor   (w_divisor),
        .o_quotient  (w_quo),
        .o_remainder (w_rem),
        .o_done_c    (w_done_c)
    );

    // The done flag is stale on the load cycle, so ignore it there.
    assign w_div_done = w_done_c && !r_start;

    // Next-state, divider operand mux and result capture.
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_start  = 1'b0;
        w_nxt_posix  = r_posix;
        w_nxt_t      = r_t;
        w_nxt_hour   = r_hour;
        w_nxt_ready  = r_ready;
        w_nxt_valid  = r_valid;
        w_nxt_hour_o = r_hour_o;
        w_nxt_min_o  = r_min_o;
        w_nxt_sec_o  = r_sec_o;
`ifdef POSIX_SPLIT_WEEKDAY_EN
        w_nxt_borrow = r_borrow;
        w_nxt_qday   = r_qday;
        w_nxt_min    = r_min;
        w_nxt_sec    = r_sec;
        w_nxt_wday_o = r_wday_o;
`endif
        w_adj        = $signed({2'b00, r_posix}) + OFFSET;
        w_dividend   = r_t;
        w_divisor    = DIVISOR_W'(SEC_IN_DAY);

        case (r_state)
            ST_IDLE: begin
                if (bus.valid_i && r_ready) begin
                    w_nxt_posix = bus.posix_time_i;
                    w_nxt_ready = 1'b0;
                    w_nxt_state = ST_ADJ;
                end
            end
            ST_ADJ: begin
                // Negative local time wraps into the previous day.
                if (w_adj[33]) begin
                    w_nxt_t = DIV_W'(w_adj + 34'(SEC_IN_DAY));
`ifdef POSIX_SPLIT_WEEKDAY_EN
                    w_nxt_borrow = 1'b1;
`endif
                end else begin
                    w_nxt_t = DIV_W'(w_adj);
`ifdef POSIX_SPLIT_WEEKDAY_EN
                    w_nxt_borrow = 1'b0;
`endif
                end
                w_nxt_state = ST_DIV_DAY;
                w_nxt_start = 1'b1;
            end
            ST_DIV_DAY: begin
                if (w_div_done) begin
                    w_nxt_state = ST_DIV_HOUR;
                    w_nxt_start = 1'b1;
                end
            end
            ST_DIV_HOUR: begin
                w_dividend = DIV_W'(w_rem);
                w_divisor  = DIVISOR_W'(SEC_IN_HOUR);
`ifdef POSIX_SPLIT_WEEKDAY_EN
                if (r_start) begin
                    w_nxt_qday = QDAY_W'(w_quo);
                end
`endif
                if (w_div_done) begin
                    w_nxt_state = ST_DIV_MIN;
                    w_nxt_start = 1'b1;
                end
            end
            ST_DIV_MIN: begin
                w_dividend = DIV_W'(w_rem);
                w_divisor  = DIVISOR_W'(SEC_IN_MIN);
                if (r_start) begin
                    w_nxt_hour = HOUR_W'(w_quo);
                end
                if (w_div_done) begin
`ifdef POSIX_SPLIT_WEEKDAY_EN
                    w_nxt_state = ST_DIV_WDAY;
                    w_nxt_start = 1'b1;
`else
                    w_nxt_state = ST_OUT;
`endif
                end
            end
`ifdef POSIX_SPLIT_WEEKDAY_EN
            ST_DIV_WDAY: begin
                w_dividend = DIV_W'(r_qday) + DIV_W'(EPOCH_WDAY) - DIV_W'(r_borrow);
                w_divisor  = DIVISOR_W'(DAYS_IN_WEEK);
                if (r_start) begin
                    w_nxt_min = MIN_W'(w_quo);
                    w_nxt_sec = SEC_W'(w_rem);
                end
                if (w_div_done) begin
                    w_nxt_state = ST_OUT;
                end
            end
`endif
            ST_OUT: begin
                // First cycle publishes the result; then hold until consumed.
                if (!r_valid) begin
                    w_nxt_hour_o = r_hour;
`ifdef POSIX_SPLIT_WEEKDAY_EN
                    w_nxt_min_o  = r_min;
                    w_nxt_sec_o  = r_sec;
                    w_nxt_wday_o = WDAY_W'(w_rem);
`else
                    w_nxt_min_o  = MIN_W'(w_quo);
                    w_nxt_sec_o  = SEC_W'(w_rem);
`endif
                    w_nxt_valid  = 1'b1;
                end else if (bus.ready_i) begin
                    w_nxt_valid = 1'b0;
                    w_nxt_ready = 1'b1;
                    w_nxt_state = ST_IDLE;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_ready = 1'b1;
                w_nxt_valid = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_start  <= 1'b0;
            r_posix  <= '0;
            r_t      <= '0;
            r_hour   <= '0;
            r_ready  <= 1'b1;
            r_valid  <= 1'b0;
            r_hour_o <= '0;
            r_min_o  <= '0;
            r_sec_o  <= '0;
`ifdef POSIX_SPLIT_WEEKDAY_EN
            r_borrow <= 1'b0;
            r_qday   <= '0;
            r_min    <= '0;
            r_sec    <= '0;
            r_wday_o <= '0;
`endif
        end else begin
            r_state  <= w_nxt_state;
            r_start  <= w_nxt_start;
            r_posix  <= w_nxt_posix;
            r_t      <= w_nxt_t;
            r_hour   <= w_nxt_hour;
            r_ready  <= w_nxt_ready;
            r_valid  <= w_nxt_valid;
            r_hour_o <= w_nxt_hour_o;
            r_min_o  <= w_nxt_min_o;
            r_sec_o  <= w_nxt_sec_o;
`ifdef POSIX_SPLIT_WEEKDAY_EN
            r_borrow <= w_nxt_borrow;
            r_qday   <= w_nxt_qday;
            r_min    <= w_nxt_min;
            r_sec    <= w_nxt_sec;
            r_wday_o <= w_nxt_wday_o;
`endif
        end
    end

    assign bus.ready_o = r_ready;
    assign bus.valid_o = r_valid;
    assign bus.hour_o  = r_hour_o;
    assign bus.min_o   = r_min_o;
    assign bus.sec_o   = r_sec_o;
`ifdef POSIX_SPLIT_WEEKDAY_EN
    assign bus.wday_o  = r_wday_o;
`endif

endmodule

// File: tb/tb_posix_time_split_seq.sv
// Self-checking bench: four splitters with GMT = 3, -5, 0, 14 share clock and reset.
// Directed vector table, backpressure and mid-conversion reset sequences, and random
// requests checked against an arithmetic reference model.
module tb_posix_time_split_seq;

`ifdef POSIX_SPLIT_WEEKDAY_EN
    localparam int LAT = 138;
`else
    localparam int LAT = 104;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] posix [4];
    logic        vin   [4];
    logic        rin   [4];
    logic        rdy   [4];
    logic        vout  [4];
    logic [4:0]  hour  [4];
    logic [5:0]  min   [4];
    logic [5:0]  sec   [4];
`ifdef POSIX_SPLIT_WEEKDAY_EN
    logic [2:0]  wday  [4];
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int GMT_G = (g == 0) ? 3 : (g == 1) ? -5 : (g == 2) ? 0 : 14;
        posix_time_split_seq_if ifc ();
        assign ifc.posix_time_i = posix[g];
        assign ifc.valid_i      = vin[g];
        assign ifc.ready_i      = rin[g];
        assign rdy[g]           = ifc.ready_o;
        assign vout[g]          = ifc.valid_o;
        assign hour[g]          = ifc.hour_o;
        assign min[g]           = ifc.min_o;
        assign sec[g]           = ifc.sec_o;
`ifdef POSIX_SPLIT_WEEKDAY_EN
        assign wday[g]          = ifc.wday_o;
`endif
        posix_time_split_seq #(.GMT(GMT_G)) u_dut (
            .clk_i (clk),
            .rst_i (rst),
            .bus   (ifc)
        );
    end

    function automatic int gmt_of(input int d);
        case (d)
            0:       return 3;
            1:       return -5;
            2:       return 0;
            default: return 14;
        endcase
    endfunction

    function automatic void check(input string name, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endfunction

    function automatic logic [16:0] outs(input int d);
        return {hour[d], min[d], sec[d]};
    endfunction

    // Local time from first principles: offset, wrap into [0, day), split.
    function automatic void model(input int gmt, input logic [31:0] p,
                                  output int h, output int m, output int s, output int w);
        longint t;
        longint days;
        longint r;
        int     b;
        t = longint'({32'd0, p}) + longint'(gmt) * 3600;
        b = 0;
        if (t < 0) begin
            t = t + 86400;
            b = 1;
        end
        days = t / 86400;
        r    = t % 86400;
        h    = int'(r / 3600);
        m    = int'((r % 3600) / 60);
        s    = int'(r % 60);
        w    = int'((days + 4 - b) % 7);
    endfunction

    task automatic conv(input int d, input logic [31:0] p, input int eh, input int em,
                        input int es, input int ew, input int hold, input bit pulse);
        int          lat;
        bit          glitch;
        bit          unstable;
        logic [16:0] snap;
        logic [16:0] expv;
        expv = {5'(eh), 6'(em), 6'(es)};
        rin[d] = (hold == 0);
        @(negedge clk);
        check("ready_idle", longint'(rdy[d]), 1);
        posix[d] = p;
        vin[d]   = 1'b1;
        @(posedge clk);
        #1;
        vin[d] = 1'b0;
        check("ready_busy", longint'(rdy[d]), 0);
        snap   = outs(d);
        lat    = 0;
        glitch = 1'b0;
        while (!vout[d] && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
            if (!vout[d] && outs(d) != snap) glitch = 1'b1;
        end
        check("latency", lat, LAT);
        check("no_glitch", longint'(glitch), 0);
        check("hour", longint'(hour[d]), eh);
        check("min", longint'(min[d]), em);
        check("sec", longint'(sec[d]), es);
`ifdef POSIX_SPLIT_WEEKDAY_EN
        check("wday", longint'(wday[d]), ew);
`endif
        unstable = 1'b0;
        for (int i = 0; i < hold; i++) begin
            if (pulse) begin
                posix[d] = $urandom;
                vin[d]   = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            if (!vout[d] || rdy[d] || outs(d) != expv) unstable = 1'b1;
        end
        vin[d] = 1'b0;
        if (hold > 0) check("hold_stable", longint'(unstable), 0);
        rin[d] = 1'b1;
        @(posedge clk);
        #1;
        check("hs_valid_low", longint'(vout[d]), 0);
        check("hs_ready_high", longint'(rdy[d]), 1);
        check("hold_after_hs", longint'(outs(d)), longint'(expv));
    endtask

    typedef struct {
        int          dut;
        logic [31:0] p;
        int          h;
        int          m;
        int          s;
        int          w;
        int          hold;
        bit          pulse;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int          h, m, s, w, d;
        bit          stale;
        logic [31:0] p;
        logic [31:0] edges [6];

        vecs[0] = '{0, 32'd0,          3,  0,  0,  4, 0,  1'b0};
        vecs[1] = '{1, 32'd0,          19, 0,  0,  3, 0,  1'b0};
        vecs[2] = '{2, 32'd1700000000, 22, 13, 20, 2, 0,  1'b0};
        vecs[3] = '{2, 32'd0,          0,  0,  0,  4, 0,  1'b0};
        vecs[4] = '{3, 32'hFFFFFFFF,   20, 28, 15, 0, 0,  1'b0};
        vecs[5] = '{3, 32'd0,          14, 0,  0,  4, 1,  1'b0};
        vecs[6] = '{1, 32'd86399,      18, 59, 59, 4, 2,  1'b0};
        vecs[7] = '{0, 32'd1700000000, 1,  13, 20, 3, 50, 1'b1};
        vecs[8] = '{1, 32'd17999,      23, 59, 59, 3, 0,  1'b0};

        edges[0] = 32'd0;
        edges[1] = 32'hFFFFFFFF;
        edges[2] = 32'd86399;
        edges[3] = 32'd86400;
        edges[4] = 32'd17999;
        edges[5] = 32'd18000;

        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            posix[i] = '0;
            vin[i]   = 1'b0;
            rin[i]   = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("rst_ready", longint'(rdy[i]), 1);
            check("rst_valid", longint'(vout[i]), 0);
            check("rst_outs", longint'(outs(i)), 0);
`ifdef POSIX_SPLIT_WEEKDAY_EN
            check("rst_wday", longint'(wday[i]), 0);
`endif
        end
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            conv(vecs[i].dut, vecs[i].p, vecs[i].h, vecs[i].m, vecs[i].s, vecs[i].w,
                 vecs[i].hold, vecs[i].pulse);
        end

        // Reset in the middle of a conversion on the GMT=-5 instance.
        @(negedge clk);
        posix[1] = 32'd12345;
        vin[1]   = 1'b1;
        @(posedge clk);
        #1;
        vin[1] = 1'b0;
        repeat (59) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_outs", longint'(outs(1)), 0);
        check("midrst_valid", longint'(vout[1]), 0);
        check("midrst_ready", longint'(rdy[1]), 1);
        @(negedge clk);
        rst   = 1'b0;
        stale = 1'b0;
        repeat (150) begin
            @(posedge clk);
            #1;
            if (vout[1]) stale = 1'b1;
        end
        check("no_stale_valid", longint'(stale), 0);
        model(gmt_of(1), 32'd12345, h, m, s, w);
        conv(1, 32'd12345, h, m, s, w, 0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            d = int'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) p = edges[$urandom_range(0, 5)];
            else p = $urandom;
            model(gmt_of(d), p, h, m, s, w);
            conv(d, p, h, m, s, w, int'($urandom_range(0, 3)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/posix_time_split_seq.md
Name: posix_time_split_seq

Overview:
Multi-cycle converter from 32-bit POSIX seconds to local hour/min/sec for the alarm-clock display and alarm-compare paths. It replaces wide combinational divide/modulo with one shared iterative divider, sequenced through successive passes: day, hour, minute. Valid/ready handshake on both sides; sits between the time source (NTP/RTC counter) and the display/alarm logic.

Parameters:
GMT, 3, signed whole-hour zone offset, legal range -12..14
DIV_CYCLES, 33, iterations per divider pass (dividend width); fixed, not user-tunable

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
posix_time_i  in  32  POSIX seconds, sampled on accept
valid_i  in  1  request valid
ready_o  out  1  block idle, can accept
hour_o  out  5  local hour 0..23
min_o  out  6  minute 0..59
sec_o  out  6  second 0..59
valid_o  out  1  result valid
ready_i  in  1  consumer accepts result

Behaviour:
- Clock is clk_i; reset is rst_i, synchronous, active-high. No other clock or reset.
- Reset values: ready_o=1, valid_o=0, hour_o=min_o=sec_o=0, FSM=IDLE, divider cleared.
- Accept: rising edge with valid_i&&ready_o; posix_time_i captured; ready_o drops next cycle.
- FSM: IDLE -> ADJ -> DIV_DAY -> DIV_HOUR -> DIV_MIN -> OUT -> IDLE.
- ADJ (1 cycle): t = posix + GMT*3600, computed as 34-bit signed. If t<0, t += 86400 and set borrow=1; else borrow=0. Result fits 33 bits unsigned.
- Each DIV state lasts exactly DIV_CYCLES+1 = 34 cycles: 1 load cycle + 33 restoring iterations. Quotient/remainder are registered at the end of the pass.
- DIV_DAY: t / 86400 -> q_day, r_day (0..86399).
- DIV_HOUR: r_day / 3600 -> hour, r_h.
- DIV_MIN: r_h / 60 -> min, sec.
- OUT: hour_o/min_o/sec_o updated and valid_o=1 on the same edge.
- Latency: valid_o first high 104 cycles after the accept edge (1 + 3*34 + 1).
- valid_o and outputs are held stable until valid_o&&ready_i. On that edge valid_o=0, ready_o=1 and FSM=IDLE. valid_i is ignored while ready_o=0.
- Outputs keep the last result after handshake; they never glitch mid-conversion.
- Synchronous reset at any cycle aborts the conversion: all outputs return to reset values on that edge and no stale valid_o is produced.
- Divider by-zero is unreachable; divisors are constants 86400/3600/60 muxed per state.
- Boundary: 0xFFFFFFFF with GMT=14 must not overflow (33-bit path).

Optional Feature:
Macro POSIX_SPLIT_WEEKDAY_EN.
- Defined:
  - Adds output wday_o (3 bits, 0=Sunday..6).
  - Adds state DIV_WDAY after DIV_MIN, computing (q_day + 4 - borrow) mod 7 with the same divider.
  - Latency becomes 138 cycles.
  - wday_o resets to 0 and follows the same hold rules as the other outputs.
- Undefined: no port, no state, latency 104.

Decomposition:
- Package posix_time_pkg:
  - SEC_IN_MIN, MIN_IN_HOUR, HOUR_IN_DAY, SEC_IN_HOUR, SEC_IN_DAY, DIV_W=33 constants
  - FSM state enum typedef
  - hour_t/min_t/sec_t widths
- One sub-module, seq_divider:
  - restoring radix-2 divider; 33-bit dividend, 17-bit divisor
  - start_i/done_o, quotient/remainder
  - fixed 34-cycle pass
- Controller owns FSM, offset adjust, divisor mux and output registers.

Test Plan:
- GMT=3, posix 0 -> 03:00:00, valid_o exactly 104 cycles after accept.
- GMT=-5, posix 0 -> 19:00:00 (borrow path); with WEEKDAY_EN, wday_o=3.
- GMT=0, posix 1700000000 -> 22:13:20; GMT=0, posix 0 with WEEKDAY_EN -> wday_o=4.
- GMT=14, posix 0xFFFFFFFF -> 20:28:15; with WEEKDAY_EN, wday_o=0.
- Backpressure: ready_i=0 for 50 cycles -> outputs and valid_o stable, ready_o=0, valid_i pulses ignored; ready_i=1 -> handshake, ready_o=1 next cycle.
- rst_i asserted in cycle 60 of a conversion -> next edge all outputs 0, ready_o=1; new request converts correctly with no stale valid_o.
